// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial WIDTH-bit adder/subtractor. A single full-adder stage processes
//   one bit per clock, LSB first. The block owns the operand shift registers,
//   the carry flip-flop, the bit counter and the start/done handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; operands and sub captured on start
//   RUN   | one bit per clock through the full-adder stage
//   DONE  | one-cycle done pulse; result and flags are valid
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   operation request, sampled only in IDLE
//   sub      in   0: a+b, 1: a-b (sampled with start)
//   a, b     in   WIDTH-bit operands (sampled with start)
//   busy     out  high in RUN and DONE
//   done     out  one-cycle pulse when result/flags are valid
//   result   out  sum/difference, held until the next operation completes
//   cout     out  carry out of MSB (for sub: 1 = no borrow)
//   overflow out  signed overflow
//   zero     out  result == 0
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] sh_r_next;

  // The single full-adder stage.
  always_comb begin
    sum_bit    = sh_a[0] ^ sh_b[0] ^ carry;
    carry_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    sh_r_next  = {sum_bit, sh_r[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_r     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          sh_r  <= sh_r_next;
          carry <= carry_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // carry here is the carry into the MSB, carry_next the carry out.
            result   <= sh_r_next;
            cout     <= carry_next;
            overflow <= carry ^ carry_next;
            zero     <= (sh_r_next == '0);
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): table-driven directed vectors,
// hand-written multi-cycle sequences and randomized operations checked
// against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int n_checks = 0;
  int n_errors = 0;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model from plain arithmetic: {result, cout, overflow, zero}.
  function automatic logic [W+2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic sv);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         ov;
    if (sv) full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else    full = {1'b0, av} + {1'b0, bv};
    r = full[W-1:0];
    if (sv) ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    else    ov = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
    return {r, full[W], ov, (r == '0)};
  endfunction

  // Drive one start request; returns after the accepting edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Watch negedges after the accepting edge; j counts edges since it.
  task automatic wait_done(output int j_done, output int busy_cnt);
    j_done   = -1;
    busy_cnt = 0;
    for (int j = 0; j < 3 * W; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        j_done = j;
        break;
      end
    end
    if (j_done < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no done within %0d cycles", 3 * W);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [W+2:0] exp);
    chk({tag, "_result"},   32'(result),   32'(exp[W+2:3]));
    chk({tag, "_cout"},     32'(cout),     32'(exp[2]));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp[1]));
    chk({tag, "_zero"},     32'(zero),     32'(exp[0]));
  endtask

  initial begin
    int jd, bc, ndone;
    logic [W+2:0] exp_v;
    logic [W+2:0] expq[$];
    logic [W-1:0] ra, rb;
    logic         rs;

    vecs[0] = '{a: 8'h3C, b: 8'h45, sub: 1'b0, res: 8'h81, c: 1'b0, ov: 1'b1, z: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, c: 1'b1, ov: 1'b0, z: 1'b1};
    vecs[2] = '{a: 8'h05, b: 8'h07, sub: 1'b1, res: 8'hFE, c: 1'b0, ov: 1'b0, z: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, res: 8'h7F, c: 1'b1, ov: 1'b1, z: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, c: 1'b0, ov: 1'b1, z: 1'b0};
    vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, res: 8'h00, c: 1'b1, ov: 1'b0, z: 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_outputs("reset", '0);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(jd, bc);
      chk("tbl_latency", 32'(jd), 32'(W));
      chk("tbl_busy_cycles", 32'(bc), 32'(W + 1));
      chk_outputs("tbl", {vecs[i].res, vecs[i].c, vecs[i].ov, vecs[i].z});
      @(negedge clk);
      chk("tbl_busy_after", 32'(busy), 32'd0);
      chk("tbl_done_after", 32'(done), 32'd0);
    end

    // Start pulses and operand changes mid-RUN are ignored.
    issue(8'h12, 8'h34, 1'b0);
    ndone = 0; bc = 0; jd = -1;
    for (int j = 0; j < 3 * W; j++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin ndone++; jd = j; end
      if (j == 3) chk_outputs("hold_in_run", {8'h00, 1'b1, 1'b0, 1'b1});
      if (done) chk_outputs("ignore_start", model(8'h12, 8'h34, 1'b0));
      a = W'($urandom); b = W'($urandom); sub = ~sub;
      start = (j == 2 || j == 5);
    end
    start = 1'b0;
    chk("ignore_ndone", 32'(ndone), 32'd1);
    chk("ignore_latency", 32'(jd), 32'(W));
    chk("ignore_busy_cycles", 32'(bc), 32'(W + 1));

    // Reset in the middle of RUN.
    issue(8'hFF, 8'hFF, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_outputs("rst", '0);
    ndone = 0;
    for (int j = 0; j < W + 3; j++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    issue(8'h10, 8'h20, 1'b0);
    wait_done(jd, bc);
    chk("post_rst_latency", 32'(jd), 32'(W));
    chk_outputs("post_rst", {8'h30, 1'b0, 1'b0, 1'b0});
    @(negedge clk);

    // Back-to-back with start held high: accepts every W+2 edges.
    @(negedge clk);
    ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
    a = ra; b = rb; sub = rs; start = 1'b1;
    expq.push_back(model(ra, rb, rs));
    @(posedge clk);
    ndone = 0;
    for (int t = 0; t < 6 * (W + 2); t++) begin
      @(negedge clk);
      chk("b2b_done_timing", 32'(done), 32'((t % (W + 2)) == W));
      if (done) begin
        ndone++;
        if (expq.size() > 0) chk_outputs("b2b", expq.pop_front());
      end
      if ((t % (W + 2)) == 0) begin
        if (t < 5 * (W + 2)) begin
          ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
          a = ra; b = rb; sub = rs;
          expq.push_back(model(ra, rb, rs));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd6);

    // Randomized operations against the reference model.
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (n % 20 == 0) rb = rs ? ra : W'(0) - ra;
      exp_v = model(ra, rb, rs);
      issue(ra, rb, rs);
      wait_done(jd, bc);
      chk("rnd_latency", 32'(jd), 32'(W));
      chk_outputs("rnd", exp_v);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
